// File: rtl/vga_sync_gen_if.sv
// VGA timing bundle: sync strobes, pixel coordinates and pixel/frame ticks.
// master drives (timing generator), slave observes (overlay / connector stage).
interface vga_sync_gen_if;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       p_tick;
  logic       frame_tick;
  logic [9:0] pix_x;
  logic [9:0] pix_y;

  modport master (
    output hsync,
    output vsync,
    output video_on,
    output p_tick,
    output frame_tick,
    output pix_x,
    output pix_y
  );

  modport slave (
    input hsync,
    input vsync,
    input video_on,
    input p_tick,
    input frame_tick,
    input pix_x,
    input pix_y
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 timing generator: free-running pixel divider, h/v counters.
// Ports: CLK, RESET (async, active-high), o_vga (vga_sync_gen_if.master).
module vga_sync_gen #(
  parameter int TICK_DIV = 2,
  parameter int H_DISP   = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_DISP   = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic           CLK,
  input  logic           RESET,
  vga_sync_gen_if.master o_vga
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DW-1:0] D_LAST = DW'(TICK_DIV - 1);
  localparam logic [DW-1:0] D_ONE  = DW'(1);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISP);
  localparam logic [9:0] V_VIS  = 10'(V_DISP);
  localparam logic [9:0] HS_BEG = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_END = 10'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_END = 10'(V_DISP + V_FP + V_SYNC - 1);

  logic [DW-1:0] r_d;
  logic [9:0]    r_h;
  logic [9:0]    r_v;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_video_on;

  logic [DW-1:0] w_d_nxt;
  logic [9:0]    w_h_nxt;
  logic [9:0]    w_v_nxt;
  logic          w_p_tick;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_hs_nxt;
  logic          w_vs_nxt;
  logic          w_von_nxt;

  assign w_p_tick = (r_d == D_LAST);
  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);

  always_comb begin
    w_d_nxt = r_d + D_ONE;
    w_h_nxt = r_h;
    w_v_nxt = r_v;
    if (w_p_tick) begin
      w_d_nxt = '0;
      if (w_h_last) begin
        w_h_nxt = '0;
        w_v_nxt = w_v_last ? 10'd0 : r_v + 10'd1;
      end else begin
        w_h_nxt = r_h + 10'd1;
      end
    end
  end

  // Strobes are decoded from the next coordinates and registered, so
  // they change on the same edge as pix_x/pix_y and never lag them.
  always_comb begin
    w_hs_nxt  = !((w_h_nxt >= HS_BEG) && (w_h_nxt <= HS_END));
    w_vs_nxt  = !((w_v_nxt >= VS_BEG) && (w_v_nxt <= VS_END));
    w_von_nxt = (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_d        <= '0;
      r_h        <= '0;
      r_v        <= '0;
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_video_on <= 1'b1;
    end else begin
      r_d        <= w_d_nxt;
      r_h        <= w_h_nxt;
      r_v        <= w_v_nxt;
      r_hsync    <= w_hs_nxt;
      r_vsync    <= w_vs_nxt;
      r_video_on <= w_von_nxt;
    end
  end

  assign o_vga.pix_x      = r_h;
  assign o_vga.pix_y      = r_v;
  assign o_vga.hsync      = r_hsync;
  assign o_vga.vsync      = r_vsync;
  assign o_vga.video_on   = r_video_on;
  assign o_vga.p_tick     = w_p_tick;
  assign o_vga.frame_tick = w_p_tick && w_h_last && w_v_last;

endmodule
